// File: rtl/stereo_frame_sequencer.sv
// Lockstep frame sequencer for NUM_CH camera channels: CAPTURE -> GRAY -> PROCESS -> DONE,
// with a per-phase watchdog, abort, continuous mode and a frame counter. Define SEQ_SKEW_MON_EN for max_skew.
module stereo_frame_sequencer #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned TIMEOUT = 2000000,
    parameter int unsigned TO_W    = 24,
    parameter int unsigned FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_mode,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] rwm1_done,
    input  logic [NUM_CH-1:0] gs_done,
    input  logic [NUM_CH-1:0] rwm2_done,
    output logic [NUM_CH-1:0] camera_enable,
    output logic [NUM_CH-1:0] rwm1_enable,
    output logic              rw_1,
    output logic [NUM_CH-1:0] gs_enable,
    output logic [NUM_CH-1:0] rwm2_enable,
    output logic              rw_2,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output logic [1:0]        err_phase,
    output logic [FCNT_W-1:0] frame_count
`ifdef SEQ_SKEW_MON_EN
    ,
    output logic [TO_W-1:0]   max_skew
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_GRAY, S_PROCESS, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [1:0]        err_phase_d;
    logic [NUM_CH-1:0] phase_done;
    logic              all_done;
    logic              timeout;
    logic              in_phase;

    always_comb begin
        case (state_q)
            S_CAPTURE: phase_done = rwm1_done;
            S_GRAY:    phase_done = gs_done;
            S_PROCESS: phase_done = rwm2_done;
            default:   phase_done = '0;
        endcase
    end

    assign in_phase = (state_q == S_CAPTURE) || (state_q == S_GRAY) || (state_q == S_PROCESS);
    assign all_done = &(sticky_q | phase_done | ~mask_q);
    assign timeout  = (wd_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sticky_d    = sticky_q;
        err_phase_d = err_phase;
        if (abort) begin
            state_d     = S_IDLE;
            sticky_d    = '0;
            err_phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (|ch_mask)) begin
                        state_d = S_CAPTURE;
                        mask_d  = ch_mask;
                    end
                end
                S_CAPTURE, S_GRAY, S_PROCESS: begin
                    // Completion is checked before the timeout so a last-cycle done still advances.
                    if (all_done) begin
                        sticky_d = '0;
                        state_d  = (state_q == S_CAPTURE) ? S_GRAY :
                                   (state_q == S_GRAY)    ? S_PROCESS : S_DONE;
                    end else if (timeout) begin
                        sticky_d    = '0;
                        state_d     = S_ERR;
                        err_phase_d = (state_q == S_CAPTURE) ? 2'd1 :
                                      (state_q == S_GRAY)    ? 2'd2 : 2'd3;
                    end else begin
                        sticky_d = sticky_q | (phase_done & mask_q);
                    end
                end
                S_DONE:  state_d = cont_mode ? S_CAPTURE : S_IDLE;
                default: state_d = state_q;
            endcase
        end
        wd_d = (in_phase && (state_d == state_q)) ? wd_q + 1'b1 : '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            sticky_q      <= '0;
            wd_q          <= '0;
            camera_enable <= '0;
            rwm1_enable   <= '0;
            rw_1          <= 1'b0;
            gs_enable     <= '0;
            rwm2_enable   <= '0;
            rw_2          <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            error         <= 1'b0;
            err_phase     <= '0;
            frame_count   <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            sticky_q      <= sticky_d;
            wd_q          <= wd_d;
            camera_enable <= (state_d == S_CAPTURE) ? mask_d : '0;
            rwm1_enable   <= ((state_d == S_CAPTURE) || (state_d == S_GRAY)) ? mask_d : '0;
            rw_1          <= (state_d == S_CAPTURE);
            gs_enable     <= (state_d == S_GRAY) ? mask_d : '0;
            rwm2_enable   <= ((state_d == S_GRAY) || (state_d == S_PROCESS)) ? mask_d : '0;
            rw_2          <= (state_d == S_GRAY);
            busy          <= (state_d == S_CAPTURE) || (state_d == S_GRAY) || (state_d == S_PROCESS);
            frame_done    <= (state_d == S_DONE);
            error         <= (state_d == S_ERR);
            err_phase     <= err_phase_d;
            if (state_d == S_DONE) frame_count <= frame_count + 1'b1;
        end
    end

`ifdef SEQ_SKEW_MON_EN
    logic [TO_W-1:0] skew_cnt_q, skew_cnt_d, max_skew_d, skew_now;

    // skew_cnt_q counts cycles since the first accumulated done bit of the current phase.
    always_comb begin
        skew_cnt_d = '0;
        max_skew_d = max_skew;
        skew_now   = (|sticky_q) ? skew_cnt_q + 1'b1 : '0;
        if (abort) begin
            max_skew_d = '0;
        end else if (in_phase) begin
            if (all_done) begin
                if (skew_now > max_skew) max_skew_d = skew_now;
            end else if (!timeout && (|sticky_q)) begin
                skew_cnt_d = skew_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_cnt_q <= '0;
            max_skew   <= '0;
        end else begin
            skew_cnt_q <= skew_cnt_d;
            max_skew   <= max_skew_d;
        end
    end
`endif

endmodule

// File: doc/stereo_frame_sequencer.md
Name: stereo_frame_sequencer

Overview:
Parametrised successor to the per-camera frame Controller. One instance sequences NUM_CH camera channels in lockstep through three phases: capture into RWM_1, grayscale from RWM_1 into RWM_2, then readout of RWM_2 to the sobel/filter chain. Adds a channel mask, continuous mode, a per-phase watchdog, an abort input and a frame counter. Sits between the camera/RWM/Grayscaler channels and the keypoint pipeline, replacing one Controller per camera.

Parameters:
NUM_CH, 2, number of camera channels.
TIMEOUT, 2000000, maximum cycles allowed per phase before error; must be >=2.
TO_W, 24, watchdog counter width; requires 2^TO_W > TIMEOUT.
FCNT_W, 16, frame counter width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  one-cycle request to begin a frame.
abort  in  1  forces return to IDLE.
cont_mode  in  1  when 1, DONE restarts automatically.
ch_mask  in  NUM_CH  enabled channels; sampled into mask_q on accepted start.
rwm1_done  in  NUM_CH  per-channel RWM_1 write/read completion pulse.
gs_done  in  NUM_CH  per-channel Grayscaler completion pulse.
rwm2_done  in  NUM_CH  per-channel RWM_2 readout completion pulse.
camera_enable  out  NUM_CH  per-channel camera enable.
rwm1_enable  out  NUM_CH  per-channel RWM_1 enable.
rw_1  out  1  RWM_1 direction: 1 = write, 0 = read.
gs_enable  out  NUM_CH  per-channel Grayscaler enable.
rwm2_enable  out  NUM_CH  per-channel RWM_2 enable.
rw_2  out  1  RWM_2 direction: 1 = write, 0 = read.
busy  out  1  high in CAPTURE, GRAY and PROCESS.
frame_done  out  1  one-cycle pulse in DONE.
error  out  1  high in ERR.
err_phase  out  2  phase that timed out: 1 = CAPTURE, 2 = GRAY, 3 = PROCESS.
frame_count  out  FCNT_W  number of completed frames; wraps modulo 2^FCNT_W.

Behaviour:
- Reset values: all outputs 0, including rw_1, rw_2 and frame_count; state IDLE; mask_q 0; sticky 0; watchdog 0.
- All outputs are registered and decode from the current state. Enables are gated by mask_q; masked-off channels keep every enable at 0.
- IDLE: on start with ch_mask != 0, latch mask_q and move to CAPTURE next cycle. start with ch_mask == 0 is ignored.
- CAPTURE: camera_enable, rwm1_enable, rw_1 = 1. Waits on rwm1_done.
- GRAY: rwm1_enable, rw_1 = 0, gs_enable, rwm2_enable, rw_2 = 1. Waits on gs_done.
- PROCESS: rwm2_enable, rw_2 = 0. Waits on rwm2_done.
- Phase completion:
  - Each cycle, sticky |= phase_done & mask_q.
  - When (sticky | phase_done | ~mask_q) is all ones, move to the next state on the following edge and clear sticky.
  - Done bits arriving in different cycles are accumulated. A repeated done bit is harmless.
  - Done inputs of phases other than the current one are ignored.
- DONE: lasts one cycle. frame_done = 1 and frame_count increments. Next state is CAPTURE if cont_mode = 1 (mask_q is kept), otherwise IDLE.
- Watchdog:
  - Cleared on entry to each busy phase; increments every cycle in that phase.
  - If the phase has not completed when the count equals TIMEOUT-1, go to ERR. Completion in that same cycle wins over the timeout.
- ERR: all enables 0; error = 1; err_phase holds the phase that timed out. Stays in ERR until abort.
- abort, from any state: next state IDLE with all enables 0, sticky cleared, error and err_phase cleared. frame_count is kept. abort has priority over start, completion and timeout.
- start while not in IDLE is ignored.
- Asynchronous reset mid-frame: all outputs drop to 0 immediately, with no completion pulse.

Optional Feature:
Macro SEQ_SKEW_MON_EN.
- Defined: adds output max_skew [TO_W-1:0], reset 0. In each phase, count the cycles from the first enabled done bit to the last. On phase completion, max_skew = max(max_skew, skew). Cleared by abort.
- Undefined: the port and logic are absent.

Test Plan:
1. NUM_CH=2, mask 2'b11, start; rwm1_done both at cycle 10, gs_done at cycle 20, rwm2_done at cycle 30 -> states CAPTURE, GRAY, PROCESS, DONE; frame_done one cycle; frame_count = 1; IDLE after.
2. rwm1_done[0] at cycle 5, rwm1_done[1] at cycle 40 -> remain in CAPTURE until cycle 40, GRAY the next cycle; with SEQ_SKEW_MON_EN, max_skew = 35.
3. mask 2'b01 -> channel 1 enables stay 0 throughout; completion needs only bit 0. start with mask 2'b00 -> stays in IDLE.
4. TIMEOUT=50, gs_done never arrives -> ERR 50 cycles after GRAY entry; error = 1, err_phase = 2, enables 0; abort -> IDLE, error = 0.
5. cont_mode = 1, three frames -> DONE goes straight to CAPTURE; frame_count counts 1, 2, 3; FCNT_W=2 wraps 3 -> 0.
6. abort in the same cycle as the final rwm2_done -> IDLE, no frame_done, frame_count unchanged; rst_n low mid-GRAY -> all outputs 0 asynchronously.
